// File: rtl/mem_bank.sv
// mem_bank: single-clock storage bank with masked writes, a registered read
// port (write-first bypass), out-of-range error pulses and a sequenced
// bulk-clear engine that zeroes one word per cycle.
module mem_bank #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] wr_mask,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              clr_start,
    output logic              busy,
    output logic              err
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    // Depth widened by one bit so addresses can be range-checked even when
    // DEPTH equals 2**ADDR_W.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic wr_in_range;
    logic rd_in_range;

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);

    // Next-state logic: the write merge and the clear step are applied to
    // mem_d first, so the read taken from mem_d naturally sees the new word
    // (write-first) or zero for the word being cleared this edge.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        busy_d     = busy_q;
        mem_d      = mem_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        err_d      = 1'b0;

        if (wr_en && !busy_q && wr_in_range) begin
            mem_d[wr_addr] = (mem_q[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
        end

        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            CLEAR: begin
                mem_d[ptr_q] = '0;
                if (ptr_q == LAST_PTR) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (rd_en) begin
            rd_valid_d = 1'b1;
            rd_data_d  = rd_in_range ? mem_d[rd_addr] : '0;
        end

        err_d = (rd_en && !rd_in_range) || (wr_en && (!wr_in_range || busy_q));
    end

    // State register: synchronous active-low reset zeroes storage and outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            busy_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
            mem_q      <= mem_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mem_bank.sv
// tb_mem_bank: drives a 4-word and a 3-word bank with shared stimulus and
// compares both against a word-level reference model every cycle.
module tb_mem_bank;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [7:0] wr_mask = '0;
    logic       rd_en = 1'b0;
    logic [1:0] rd_addr = '0;
    logic       clr_start = 1'b0;

    logic [7:0] rdData4, rdData3;
    logic       rdValid4, rdValid3, busy4, busy3, err4, err3;

    int testCount = 0;
    int failCount = 0;

    // Reference model: per bank, its words plus how many words the clear
    // still has to wipe and which word comes next.
    logic [7:0] mMem [2][4];
    int         mDepth [2] = '{4, 3};
    int         clrLeft [2];
    int         clrIdx [2];
    logic [7:0] mRd [2];
    logic       mValid [2];
    logic       mErr [2];

    always #5 clock = ~clock;

    mem_bank #(.DATA_W(8), .DEPTH(4), .ADDR_W(2)) dut4 (
        .clock(clock), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdData4), .rd_valid(rdValid4),
        .clr_start(clr_start), .busy(busy4), .err(err4)
    );

    mem_bank #(.DATA_W(8), .DEPTH(3), .ADDR_W(2)) dut3 (
        .clock(clock), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdData3), .rd_valid(rdValid3),
        .clr_start(clr_start), .busy(busy3), .err(err3)
    );

    // Advance the model by one rising edge using the inputs present there.
    task automatic modelEdge();
        bit wasBusy;
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                for (int i = 0; i < 4; i++) mMem[k][i] = 8'h00;
                clrLeft[k] = 0;
                clrIdx[k]  = 0;
                mRd[k]     = 8'h00;
                mValid[k]  = 1'b0;
                mErr[k]    = 1'b0;
            end else begin
                wasBusy = (clrLeft[k] > 0);
                mErr[k] = (rd_en && int'(rd_addr) >= mDepth[k]) ||
                          (wr_en && (int'(wr_addr) >= mDepth[k] || wasBusy));
                if (wr_en && !wasBusy && int'(wr_addr) < mDepth[k])
                    mMem[k][wr_addr] = (mMem[k][wr_addr] & ~wr_mask) | (wr_data & wr_mask);
                if (wasBusy) begin
                    mMem[k][clrIdx[k]] = 8'h00;
                    clrIdx[k]++;
                    clrLeft[k]--;
                end else if (clr_start) begin
                    clrLeft[k] = mDepth[k];
                    clrIdx[k]  = 0;
                end
                if (rd_en) begin
                    mValid[k] = 1'b1;
                    mRd[k]    = (int'(rd_addr) < mDepth[k]) ? mMem[k][rd_addr] : 8'h00;
                end else begin
                    mValid[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll();
        checkOutput("rdData4",  rdData4,  mRd[0]);
        checkOutput("rdValid4", {7'b0, rdValid4}, {7'b0, mValid[0]});
        checkOutput("busy4",    {7'b0, busy4},    {7'b0, clrLeft[0] > 0});
        checkOutput("err4",     {7'b0, err4},     {7'b0, mErr[0]});
        checkOutput("rdData3",  rdData3,  mRd[1]);
        checkOutput("rdValid3", {7'b0, rdValid3}, {7'b0, mValid[1]});
        checkOutput("busy3",    {7'b0, busy3},    {7'b0, clrLeft[1] > 0});
        checkOutput("err3",     {7'b0, err3},     {7'b0, mErr[1]});
    endtask

    // One clock of stimulus: drive on the falling edge, update the model at
    // the rising edge, then compare outputs 1 time unit later.
    task automatic applyStimulus(input logic rst, input logic we, input logic [1:0] wa,
                                 input logic [7:0] wd, input logic [7:0] wm,
                                 input logic re, input logic [1:0] ra, input logic cs);
        @(negedge clock);
        reset     = rst;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        wr_mask   = wm;
        rd_en     = re;
        rd_addr   = ra;
        clr_start = cs;
        @(posedge clock);
        modelEdge();
        #1;
        checkAll();
    endtask

    task automatic idle();
        applyStimulus(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic readAddr(input logic [1:0] a);
        applyStimulus(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, a, 1'b0);
    endtask

    task automatic writeAddr(input logic [1:0] a, input logic [7:0] d, input logic [7:0] m);
        applyStimulus(1'b1, 1'b1, a, d, m, 1'b0, 2'd0, 1'b0);
    endtask

    // Directed steps following the test plan, then a randomized soak.
    initial begin
        // Reset sanity
        applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0);
        checkOutput("rstValid", {7'b0, rdValid4}, 8'h00);
        checkOutput("rstBusy",  {7'b0, busy4},    8'h00);
        for (int a = 0; a < 4; a++) begin
            readAddr(2'(a));
            checkOutput("rstRead",  rdData4, 8'h00);
            checkOutput("rstRdVal", {7'b0, rdValid4}, 8'h01);
            checkOutput("rstErr",   {7'b0, err4},     8'h00);
        end

        // Masked write
        writeAddr(2'd2, 8'hA5, 8'hFF);
        writeAddr(2'd2, 8'h3C, 8'h0F);
        readAddr(2'd2);
        checkOutput("maskedRead", rdData4, 8'hAC);
        readAddr(2'd0);
        checkOutput("otherWord", rdData4, 8'h00);

        // Write-first bypass
        applyStimulus(1'b1, 1'b1, 2'd1, 8'h77, 8'hFF, 1'b1, 2'd1, 1'b0);
        checkOutput("bypassData",  rdData4, 8'h77);
        checkOutput("bypassValid", {7'b0, rdValid4}, 8'h01);

        // Out of range on the 3-word bank
        writeAddr(2'd3, 8'h99, 8'hFF);
        checkOutput("oorWrErr3", {7'b0, err3}, 8'h01);
        checkOutput("oorWrErr4", {7'b0, err4}, 8'h00);
        idle();
        checkOutput("errPulse3", {7'b0, err3}, 8'h00);
        readAddr(2'd3);
        checkOutput("oorRdData3",  rdData3, 8'h00);
        checkOutput("oorRdValid3", {7'b0, rdValid3}, 8'h01);
        checkOutput("oorRdErr3",   {7'b0, err3},     8'h01);

        // Bulk clear
        writeAddr(2'd0, 8'h11, 8'hFF);
        writeAddr(2'd1, 8'h22, 8'hFF);
        writeAddr(2'd2, 8'h33, 8'hFF);
        writeAddr(2'd3, 8'h44, 8'hFF);
        applyStimulus(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 2'd0, 1'b1);
        checkOutput("clrBusy0", {7'b0, busy4}, 8'h01);
        applyStimulus(1'b1, 1'b1, 2'd0, 8'hEE, 8'hFF, 1'b1, 2'd3, 1'b0);
        checkOutput("clrReadOld", rdData4, 8'h44);
        checkOutput("busyWrErr",  {7'b0, err4},  8'h01);
        checkOutput("clrBusy1",   {7'b0, busy4}, 8'h01);
        idle();
        checkOutput("clrBusy2", {7'b0, busy4}, 8'h01);
        idle();
        checkOutput("clrBusy3", {7'b0, busy4}, 8'h01);
        idle();
        checkOutput("clrDone", {7'b0, busy4}, 8'h00);
        for (int a = 0; a < 4; a++) begin
            readAddr(2'(a));
            checkOutput("clrRead", rdData4, 8'h00);
        end

        // Reset mid-clear
        writeAddr(2'd0, 8'h5A, 8'hFF);
        applyStimulus(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 2'd0, 1'b1);
        idle();
        applyStimulus(1'b0, 1'b1, 2'd1, 8'hFF, 8'hFF, 1'b1, 2'd0, 1'b1);
        checkOutput("midRstBusy",  {7'b0, busy4},    8'h00);
        checkOutput("midRstValid", {7'b0, rdValid4}, 8'h00);
        checkOutput("midRstErr",   {7'b0, err4},     8'h00);
        for (int a = 0; a < 4; a++) begin
            readAddr(2'(a));
            checkOutput("midRstRead", rdData4, 8'h00);
        end
        applyStimulus(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 2'd0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            idle();
            checkOutput("reClrBusy", {7'b0, busy4}, (i < 4) ? 8'h01 : 8'h00);
        end

        // Randomized soak against the model
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(63) != 0),
                          1'($urandom_range(1)), 2'($urandom_range(3)),
                          8'($urandom), 8'($urandom),
                          1'($urandom_range(1)), 2'($urandom_range(3)),
                          ($urandom_range(15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/mem_bank.md
Name: mem_bank

Overview:
- Parametrised single-clock storage bank with independent write and read ports.
- Supports per-bit write mask, registered read with a valid strobe and write-first bypass, out-of-range error flagging, and a sequenced bulk-clear engine.
- Used as general scratch/register storage behind the datapath; its default configuration matches the existing 4 x 8-bit cell.

Parameters:
- DATA_W, 8: word width in bits.
- DEPTH, 4: number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W.
- ADDR_W, 2: address width in bits.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset.
- wr_en  input  1  write request.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data.
- wr_mask  input  DATA_W  per-bit write enable; 1 = update that bit.
- rd_en  input  1  read request.
- rd_addr  input  ADDR_W  read address.
- rd_data  output  DATA_W  registered read data.
- rd_valid  output  1  one-cycle strobe: rd_data is fresh this cycle.
- clr_start  input  1  request bulk clear of all words.
- busy  output  1  high while the clear engine runs.
- err  output  1  one-cycle pulse flagging a rejected or out-of-range access.

Behaviour:
- Reset: reset is synchronous, active-low, clocked on clock. When reset==0 at an edge:
  - all DEPTH words become 0;
  - rd_data=0, rd_valid=0, busy=0, err=0;
  - FSM goes to IDLE and the clear pointer becomes 0.
  - Reset overrides every other input, including mid-clear.
- Write: at an edge with wr_en=1, busy=0 and wr_addr<DEPTH, mem[wr_addr] <= (mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask). wr_mask=0 leaves the word unchanged and is not an error.
- Read: latency 1.
  - If rd_en=1 at edge N, rd_data is updated and rd_valid=1 during the cycle after edge N.
  - If rd_en=0, rd_valid=0 and rd_data holds its previous value.
  - Reads are accepted while busy.
- Read-during-write: a same-edge read of the address being written returns the post-merge (new) word.
- Read-during-clear: a same-edge read of the address being cleared returns 0. Addresses not yet reached by the clear return their old contents.
- Out of range:
  - rd_addr>=DEPTH with rd_en=1: rd_data=0, rd_valid=1.
  - wr_addr>=DEPTH with wr_en=1: write dropped, memory unchanged.
- err: pulses high for exactly one cycle after an edge on which any of these occurred:
  - out-of-range read;
  - out-of-range write;
  - wr_en=1 while busy=1.
  - Multiple causes on one edge still give a single one-cycle pulse.
- Clear FSM (states IDLE, CLEAR):
  - IDLE -> CLEAR on an edge with clr_start=1; ptr<=0, busy<=1.
  - In CLEAR, each edge writes 0 to mem[ptr] and increments ptr.
  - When ptr==DEPTH-1, that edge writes the last word, returns to IDLE and sets busy<=0.
  - busy is therefore high for exactly DEPTH cycles.
  - clr_start while busy is ignored; it is not an error.
- Simultaneous clr_start and a legal write in IDLE: the write is performed at that edge and the clear starts. The final contents are all zero.
- All outputs are registered; there are no combinational input-to-output paths.

Test Plan:
- Reset sanity (defaults): hold reset=0 for 2 cycles, release, then read addresses 0..3 -> rd_data=0x00 with rd_valid=1 one cycle after each rd_en; err stays 0 throughout.
- Masked write: write 0xA5 mask 0xFF to addr 2, then 0x3C mask 0x0F to addr 2, then read addr 2 -> 0xAC one cycle later; other addresses still 0x00.
- Bypass: on the same edge write 0x77 mask 0xFF to addr 1 and read addr 1 -> next cycle rd_data=0x77, rd_valid=1.
- Out of range (DEPTH=3, ADDR_W=2):
  - write addr 3 -> err pulses 1 cycle; memory unchanged.
  - read addr 3 -> rd_data=0x00, rd_valid=1, err pulse.
- Bulk clear:
  - Fill addresses 0..3 with 0x11,0x22,0x33,0x44, then pulse clr_start -> busy high exactly 4 cycles.
  - A write issued during busy is dropped with an err pulse.
  - A read of addr 3 on the first busy edge returns 0x44.
  - After busy falls, all reads return 0x00.
- Reset mid-clear: assert reset=0 on the 2nd busy cycle -> next cycle busy=0, rd_valid=0, err=0; all words read 0x00; a new clr_start runs a full 4-cycle clear.
